// File: rtl/ctu_scan_seq_pkg.sv
// Shared types and constants for the CTU scan-test sequencer.
package ctu_scan_seq_pkg;

    localparam int LEN_W_DEF = 16;
    localparam int CAP_W_DEF = 4;
    localparam int PAT_W_DEF = 8;

    // A configured chain length or capture count of zero runs as this value.
    localparam int ZERO_FIX = 1;

    typedef enum logic [7:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_SETUP    = 8'b0000_0010,
        ST_SHIFT    = 8'b0000_0100,
        ST_SETTLE_A = 8'b0000_1000,
        ST_CAPTURE  = 8'b0001_0000,
        ST_SETTLE_B = 8'b0010_0000,
        ST_UNLOAD   = 8'b0100_0000,
        ST_DONE     = 8'b1000_0000
    } state_e;

endpackage

// File: rtl/ctu_scan_seq_ctl_if.sv
// Control/status bundle between the CTU and the scan sequencer.
interface ctu_scan_seq_ctl_if
    import ctu_scan_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CAP_W = CAP_W_DEF,
    parameter int PAT_W = PAT_W_DEF
);
    logic             start;
    logic             cfg_short_chain;
    logic [LEN_W-1:0] cfg_long_len;
    logic [LEN_W-1:0] cfg_short_len;
    logic [CAP_W-1:0] cfg_cap_cyc;
    logic [PAT_W-1:0] cfg_num_pat;
    logic             abort_req;
    logic             global_shift_enable;
    logic             ctu_tst_short_chain;
    logic             capture_en;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, cfg_short_chain, cfg_long_len, cfg_short_len,
               cfg_cap_cyc, cfg_num_pat, abort_req,
        input  global_shift_enable, ctu_tst_short_chain, capture_en,
               busy, done, aborted
    );

    modport slave (
        input  start, cfg_short_chain, cfg_long_len, cfg_short_len,
               cfg_cap_cyc, cfg_num_pat, abort_req,
        output global_shift_enable, ctu_tst_short_chain, capture_en,
               busy, done, aborted
    );

endinterface

// File: rtl/ctu_scan_seq_cnt.sv
// Loadable down-counter; tc flags the last counted cycle (count == 1).
module ctu_scan_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);
    logic [W-1:0] cnt_r;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == W'(1));

endmodule

// File: rtl/ctu_scan_seq_ctl.sv
// Scan-test sequencer: shift / settle / capture / settle per pattern, then unload.
// Optional abort support is enabled by defining CTU_SCAN_SEQ_ABORT_EN.
module ctu_scan_seq_ctl
    import ctu_scan_seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CAP_W = CAP_W_DEF,
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_l,
    ctu_scan_seq_ctl_if.slave   bus
);
    state_e           state_r;
    state_e           state_nxt_s;
    state_e           fsm_nxt_s;

    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_sel_s;
    logic [LEN_W-1:0] len_fix_s;
    logic [CAP_W-1:0] cap_r;
    logic [CAP_W-1:0] cap_fix_s;
    logic [PAT_W-1:0] pat_r;

    logic short_r;
    logic gse_r;
    logic cap_en_r;
    logic busy_r;
    logic done_r;
    logic aborted_r;

    logic launch_s;
    logic abort_s;
    logic sh_load_s, sh_dec_s, sh_tc_s;
    logic cp_load_s, cp_dec_s, cp_tc_s;
    logic pt_load_s, pt_dec_s, pt_tc_s;

    assign launch_s = (state_r == ST_IDLE) && bus.start;

`ifdef CTU_SCAN_SEQ_ABORT_EN
    assign abort_s = bus.abort_req && (state_r != ST_IDLE) && (state_r != ST_DONE);
`else
    assign abort_s = 1'b0;
`endif

    // Chain-length selection and zero fix-up of the incoming configuration.
    always_comb begin
        len_sel_s = bus.cfg_short_chain ? bus.cfg_short_len : bus.cfg_long_len;
        if (len_sel_s == {LEN_W{1'b0}}) begin
            len_fix_s = LEN_W'(ZERO_FIX);
        end else begin
            len_fix_s = len_sel_s;
        end
        if (bus.cfg_cap_cyc == {CAP_W{1'b0}}) begin
            cap_fix_s = CAP_W'(ZERO_FIX);
        end else begin
            cap_fix_s = bus.cfg_cap_cyc;
        end
    end

    // Next-state decode; an accepted abort overrides the normal transition.
    always_comb begin
        fsm_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) fsm_nxt_s = ST_SETUP;
                else           fsm_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (pat_r == {PAT_W{1'b0}}) fsm_nxt_s = ST_DONE;
                else                        fsm_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sh_tc_s) fsm_nxt_s = ST_SETTLE_A;
                else         fsm_nxt_s = ST_SHIFT;
            end
            ST_SETTLE_A: fsm_nxt_s = ST_CAPTURE;
            ST_CAPTURE: begin
                if (cp_tc_s) fsm_nxt_s = ST_SETTLE_B;
                else         fsm_nxt_s = ST_CAPTURE;
            end
            ST_SETTLE_B: begin
                if (pt_tc_s) fsm_nxt_s = ST_UNLOAD;
                else         fsm_nxt_s = ST_SHIFT;
            end
            ST_UNLOAD: begin
                if (sh_tc_s) fsm_nxt_s = ST_DONE;
                else         fsm_nxt_s = ST_UNLOAD;
            end
            ST_DONE: fsm_nxt_s = ST_IDLE;
            default: fsm_nxt_s = ST_IDLE;
        endcase
        state_nxt_s = abort_s ? ST_IDLE : fsm_nxt_s;
    end

    // Counter controls: each counter loads on entry to the state it times.
    always_comb begin
        sh_load_s = ((state_nxt_s == ST_SHIFT)  && (state_r != ST_SHIFT)) ||
                    ((state_nxt_s == ST_UNLOAD) && (state_r != ST_UNLOAD));
        sh_dec_s  = (state_r == ST_SHIFT) || (state_r == ST_UNLOAD);
        cp_load_s = (state_nxt_s == ST_CAPTURE) && (state_r != ST_CAPTURE);
        cp_dec_s  = (state_r == ST_CAPTURE);
        pt_load_s = (state_r == ST_SETUP);
        pt_dec_s  = (state_r == ST_SETTLE_B);
    end

    ctu_scan_seq_cnt #(.W(LEN_W)) u_shift_cnt (
        .clk      (clk),
        .rst_l    (rst_l),
        .load     (sh_load_s),
        .load_val (len_r),
        .dec      (sh_dec_s),
        .tc       (sh_tc_s)
    );

    ctu_scan_seq_cnt #(.W(CAP_W)) u_cap_cnt (
        .clk      (clk),
        .rst_l    (rst_l),
        .load     (cp_load_s),
        .load_val (cap_r),
        .dec      (cp_dec_s),
        .tc       (cp_tc_s)
    );

    ctu_scan_seq_cnt #(.W(PAT_W)) u_pat_cnt (
        .clk      (clk),
        .rst_l    (rst_l),
        .load     (pt_load_s),
        .load_val (pat_r),
        .dec      (pt_dec_s),
        .tc       (pt_tc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Configuration snapshot taken when a sequence is launched.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            len_r <= {LEN_W{1'b0}};
            cap_r <= {CAP_W{1'b0}};
            pat_r <= {PAT_W{1'b0}};
        end else if (launch_s) begin
            len_r <= len_fix_s;
            cap_r <= cap_fix_s;
            pat_r <= bus.cfg_num_pat;
        end else begin
            len_r <= len_r;
            cap_r <= cap_r;
            pat_r <= pat_r;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            gse_r     <= 1'b0;
            cap_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            short_r   <= 1'b0;
        end else begin
            gse_r     <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_UNLOAD);
            cap_en_r  <= (state_nxt_s == ST_CAPTURE);
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            aborted_r <= abort_s;
            if (launch_s) begin
                short_r <= bus.cfg_short_chain;
            end else if (state_nxt_s == ST_IDLE) begin
                short_r <= 1'b0;
            end else begin
                short_r <= short_r;
            end
        end
    end

    assign bus.global_shift_enable = gse_r;
    assign bus.capture_en          = cap_en_r;
    assign bus.busy                = busy_r;
    assign bus.done                = done_r;
    assign bus.aborted             = aborted_r;
    assign bus.ctu_tst_short_chain = short_r;

endmodule

// File: tb/tb_ctu_scan_seq_ctl.sv
// Self-checking bench for ctu_scan_seq_ctl: table vectors, hand sequences, random configs.
module tb_ctu_scan_seq_ctl;
    import ctu_scan_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_l = 1'b0;

    ctu_scan_seq_ctl_if bus ();

    ctu_scan_seq_ctl dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Output vector: {aborted, short_chain, busy, shift_en, capture_en, done}
    typedef logic [5:0] vec_t;
    vec_t exp_q[$];

    typedef struct {
        string nm;
        bit    sh;
        int    ll, sl, c, p;
        int    exp_done, exp_gse, exp_cap;
    } vec_rec_t;
    vec_rec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t sample();
        return {bus.aborted, bus.ctu_tst_short_chain, bus.busy,
                bus.global_shift_enable, bus.capture_en, bus.done};
    endfunction

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected per-cycle waveform, cycle k (k>=1 after the start edge) at index k-1.
    task automatic build_model(input bit sh, input int ll, input int sl, input int c,
                               input int p, input int abort_at);
        int L, C;
        vec_t v;
        exp_q.delete();
        L = sh ? sl : ll;
        if (L == 0) L = 1;
        C = (c == 0) ? 1 : c;
        exp_q.push_back({1'b0, sh, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < p; i++) begin
            repeat (L) exp_q.push_back({1'b0, sh, 1'b1, 1'b1, 1'b0, 1'b0});
            exp_q.push_back({1'b0, sh, 1'b1, 1'b0, 1'b0, 1'b0});
            repeat (C) exp_q.push_back({1'b0, sh, 1'b1, 1'b0, 1'b1, 1'b0});
            exp_q.push_back({1'b0, sh, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        if (p > 0) repeat (L) exp_q.push_back({1'b0, sh, 1'b1, 1'b1, 1'b0, 1'b0});
        exp_q.push_back({1'b0, sh, 1'b1, 1'b0, 1'b0, 1'b1});
        exp_q.push_back(6'b000000);
`ifdef CTU_SCAN_SEQ_ABORT_EN
        if (abort_at > 0 && abort_at < exp_q.size()) begin
            v = exp_q[abort_at-1];
            if (v[3] && !v[0]) begin
                while (exp_q.size() > abort_at) void'(exp_q.pop_back());
                exp_q.push_back(6'b100000);
                exp_q.push_back(6'b000000);
            end
        end
`else
        v = 6'b000000;
`endif
    endtask

    task automatic run_seq(input string nm, input bit sh, input int ll, input int sl,
                           input int c, input int p, input int exp_done, input int exp_gse,
                           input int exp_cap, input int abort_at, input int sp1, input int sp2);
        vec_t act, prev;
        int first_bad, done_at, n_gse, n_cap, adj, n;
        build_model(sh, ll, sl, c, p, abort_at);
        n = exp_q.size();
        bus.cfg_short_chain = sh;
        bus.cfg_long_len    = ll[15:0];
        bus.cfg_short_len   = sl[15:0];
        bus.cfg_cap_cyc     = c[3:0];
        bus.cfg_num_pat     = p[7:0];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        prev = 6'b000000;
        first_bad = -1; done_at = -1; n_gse = 0; n_cap = 0; adj = 0;
        for (int k = 1; k <= n; k++) begin
            act = sample();
            if (act !== exp_q[k-1] && first_bad < 0) first_bad = k;
            if (act[0] === 1'b1 && done_at < 0) done_at = k;
            n_gse += int'(act[2]);
            n_cap += int'(act[1]);
            if ((act[2] & act[1]) | (prev[2] & act[1]) | (prev[1] & act[2])) adj++;
            prev = act;
            bus.abort_req = (k == abort_at);
            bus.start     = (k == sp1) || (k == sp2);
            tick();
        end
        bus.abort_req = 1'b0;
        bus.start     = 1'b0;
        check({nm, " first_bad_cycle"}, first_bad, -1);
        check({nm, " done_cycle"}, done_at, exp_done);
        check({nm, " shift_cycles"}, n_gse, exp_gse);
        check({nm, " capture_cycles"}, n_cap, exp_cap);
        check({nm, " enable_overlap"}, adj, 0);
    endtask

    initial begin
        int sh, ll, sl, c, p, L, C, ed;

        tbl[0] = '{"long_l4_c2_p2",   1'b0,   4, 9, 2, 2, 22, 12, 4};
        tbl[1] = '{"short_l3_c1_p1",  1'b1, 100, 3, 1, 1, 11,  6, 1};
        tbl[2] = '{"p0",              1'b0,   5, 2, 3, 0,  2,  0, 0};
        tbl[3] = '{"l0_c0_p1",        1'b0,   0, 4, 0, 1,  7,  2, 1};
        tbl[4] = '{"short_l0_c0_p3",  1'b1,   7, 0, 0, 3, 15,  4, 3};

        bus.start = 1'b0; bus.abort_req = 1'b0; bus.cfg_short_chain = 1'b0;
        bus.cfg_long_len = 16'd0; bus.cfg_short_len = 16'd0;
        bus.cfg_cap_cyc = 4'd0; bus.cfg_num_pat = 8'd0;
        rst_l = 1'b0;
        tick(); tick();
        check("reset_outputs", sample(), 6'b000000);
        rst_l = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            run_seq(tbl[i].nm, tbl[i].sh, tbl[i].ll, tbl[i].sl, tbl[i].c, tbl[i].p,
                    tbl[i].exp_done, tbl[i].exp_gse, tbl[i].exp_cap, 0, 0, 0);

        // start pulses while busy (including in DONE) must not alter the run
        run_seq("busy_start", 1'b0, 4, 9, 2, 2, 22, 12, 4, 0, 3, 22);
        // abort in DONE is never honoured
        run_seq("abort_in_done", 1'b0, 4, 9, 2, 2, 22, 12, 4, 22, 0, 0);
        // abort during the first capture cycle
`ifdef CTU_SCAN_SEQ_ABORT_EN
        run_seq("abort_capture", 1'b0, 4, 9, 3, 2, -1, 4, 1, 7, 0, 0);
`else
        run_seq("abort_capture", 1'b0, 4, 9, 3, 2, 24, 12, 6, 7, 0, 0);
`endif

        // reset in the middle of SHIFT, then restart
        bus.cfg_short_chain = 1'b1; bus.cfg_short_len = 16'd10;
        bus.cfg_cap_cyc = 4'd2; bus.cfg_num_pat = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("mid_shift_enable", int'(bus.global_shift_enable), 1);
        rst_l = 1'b0;
        tick();
        check("mid_shift_reset", sample(), 6'b000000);
        rst_l = 1'b1;
        tick();
        check("post_reset_idle", sample(), 6'b000000);
        run_seq("restart", tbl[0].sh, tbl[0].ll, tbl[0].sl, tbl[0].c, tbl[0].p,
                tbl[0].exp_done, tbl[0].exp_gse, tbl[0].exp_cap, 0, 0, 0);

        // random configurations; expectations from the latency formula
        for (int r = 0; r < 20; r++) begin
            sh = int'($urandom_range(0, 1));
            ll = int'($urandom_range(0, 6));
            sl = int'($urandom_range(0, 6));
            c  = int'($urandom_range(0, 3));
            p  = int'($urandom_range(0, 3));
            L  = (sh != 0) ? sl : ll;
            if (L == 0) L = 1;
            C  = (c == 0) ? 1 : c;
            ed = (p == 0) ? 2 : 1 + p * (L + C + 2) + L + 1;
            run_seq($sformatf("rand%0d", r), sh[0], ll, sl, c, p, ed,
                    (p == 0) ? 0 : (p + 1) * L, p * C, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
